// File: rtl/irq_controller.sv
`default_nettype none
// ============================================================================
//  Module      : irq_controller
//  Description : 68000-style seven-level interrupt controller. Synchronises
//                raw sources, latches them as edge or level requests, masks
//                and prioritises them into an encoded IPL, and handles the
//                interrupt-acknowledge handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module irq_controller #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  src,
    input  logic        cs,
    input  logic [1:0]  wr,
    input  logic [1:0]  address,
    input  logic [15:0] din,
    output logic [15:0] dout,
    input  logic        iack,
    input  logic [2:0]  iack_level,
    output logic [2:0]  ipl_n,
    output logic        irq_active
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_ACKED = 1'b1
    } state_t;

    localparam logic [6:0] c_mode_reset = 7'h7F;
    localparam logic [1:0] c_addr_pend  = 2'd0;
    localparam logic [1:0] c_addr_mask  = 2'd1;
    localparam logic [1:0] c_addr_mode  = 2'd2;
    localparam logic [1:0] c_addr_force = 2'd3;

    logic [6:0] r_sync [SYNC_STAGES];
    logic [6:0] r_hist;
    logic [6:0] r_pending;
    logic [6:0] r_mask;
    logic [6:0] r_mode;
    logic [2:0] r_cur_level;
    logic       r_iack_d;
    state_t     r_state;

    logic [6:0] w_src_s;
    logic [6:0] w_rise;
    logic       w_wr;
    logic [6:0] w_w1c;
    logic [6:0] w_force;
    logic [6:0] w_set;
    logic [6:0] w_ack_clr;
    logic [2:0] w_prio;
    logic       w_iack_rise;
    logic       w_unused;

    // Upper data byte and upper strobe carry no register bits.
    assign w_unused = ^{din[15:7], wr[1]};

    assign w_src_s     = r_sync[SYNC_STAGES-1];
    assign w_rise      = w_src_s & ~r_hist;
    assign w_wr        = cs & wr[0];
    assign w_w1c       = (w_wr && address == c_addr_pend)  ? din[6:0] : 7'h00;
    assign w_force     = (w_wr && address == c_addr_force) ? din[6:0] : 7'h00;
    assign w_iack_rise = iack & ~r_iack_d;

    // Requests that set pending this cycle: edges, live levels and FORCE.
    assign w_set = (r_mode & w_rise) | (~r_mode & w_src_s) | w_force;

    // Source synchroniser chain plus one history flop for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                r_sync[s] <= '0;
            end
            r_hist <= '0;
        end else begin
            r_sync[0] <= src;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
            r_hist <= w_src_s;
        end
    end

    // Acknowledge clears only the edge-mode bit matching the presented level.
    always_comb begin
        w_ack_clr = 7'h00;
        if (r_state == S_IDLE && w_iack_rise && r_cur_level != 3'd0 &&
            iack_level == r_cur_level) begin
            for (int i = 0; i < 7; i++) begin
                if (r_cur_level == 3'(i + 1) && r_mode[i]) begin
                    w_ack_clr[i] = 1'b1;
                end
            end
        end
    end

    // Highest enabled pending request wins; level is index+1.
    always_comb begin
        w_prio = 3'd0;
        for (int i = 0; i < 7; i++) begin
            if (r_pending[i] && r_mask[i]) begin
                w_prio = 3'(i + 1);
            end
        end
    end

    // Pending, MASK and MODE registers; a set always beats a clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending <= '0;
            r_mask    <= '0;
            r_mode    <= c_mode_reset;
        end else begin
            r_pending <= (r_pending & ~w_w1c & ~w_ack_clr) | w_set;
            if (w_wr && address == c_addr_mask) begin
                r_mask <= din[6:0];
            end
            if (w_wr && address == c_addr_mode) begin
                r_mode <= din[6:0];
            end
        end
    end

    // Acknowledge FSM and presented level; iack history resets high so an
    // acknowledge still in flight across reset is not mistaken for a new one.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cur_level <= 3'd0;
            r_iack_d    <= 1'b1;
        end else begin
            r_iack_d <= iack;
            case (r_state)
                S_IDLE: begin
                    if (w_iack_rise) begin
                        r_state     <= S_ACKED;
                        r_cur_level <= 3'd0;
                    end else begin
                        r_cur_level <= w_prio;
                    end
                end
                S_ACKED: begin
                    r_cur_level <= 3'd0;
                    if (!iack) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_cur_level <= 3'd0;
                end
            endcase
        end
    end

    assign ipl_n      = ~r_cur_level;
    assign irq_active = |r_cur_level;

    // Register read mux; FORCE reads back as zero.
    always_comb begin
        dout = 16'h0000;
        case (address)
            c_addr_pend:  dout = {4'b0000, (r_state == S_ACKED), r_cur_level, 1'b0, r_pending};
            c_addr_mask:  dout = {9'd0, r_mask};
            c_addr_mode:  dout = {9'd0, r_mode};
            c_addr_force: dout = 16'h0000;
            default:      dout = 16'h0000;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_irq_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_irq_controller
//  Description : Directed self-checking bench for irq_controller.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_irq_controller;

    logic        clk;
    logic        reset;
    logic [6:0]  src;
    logic        cs;
    logic [1:0]  wr;
    logic [1:0]  address;
    logic [15:0] din;
    logic [15:0] dout;
    logic        iack;
    logic [2:0]  iack_level;
    logic [2:0]  ipl_n;
    logic        irq_active;

    int n_checks = 0;
    int n_fail   = 0;

    irq_controller #(.SYNC_STAGES(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .src        (src),
        .cs         (cs),
        .wr         (wr),
        .address    (address),
        .din        (din),
        .dout       (dout),
        .iack       (iack),
        .iack_level (iack_level),
        .ipl_n      (ipl_n),
        .irq_active (irq_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Single lower-byte register write, committed on the next edge.
    task automatic reg_write(input logic [1:0] a, input logic [15:0] d);
        cs = 1'b1; wr = 2'b01; address = a; din = d;
        tick(1);
        cs = 1'b0; wr = 2'b00; din = 16'h0000; address = 2'd0;
        #1;
    endtask

    // Select a register for a combinational read.
    task automatic sel(input logic [1:0] a);
        address = a;
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        #1;
        n_checks++; if (ipl_n !== 3'b111) begin n_fail++; $display("FAIL reset_ipl: got %b expected 111", ipl_n); end
        n_checks++; if (irq_active !== 1'b0) begin n_fail++; $display("FAIL reset_active: got %b expected 0", irq_active); end
        sel(2'd0);
        n_checks++; if (dout !== 16'h0000) begin n_fail++; $display("FAIL reset_pending: got %h expected 0000", dout); end
        sel(2'd1);
        n_checks++; if (dout !== 16'h0000) begin n_fail++; $display("FAIL reset_mask: got %h expected 0000", dout); end
        sel(2'd2);
        n_checks++; if (dout !== 16'h007F) begin n_fail++; $display("FAIL reset_mode: got %h expected 007f", dout); end
        sel(2'd0);
    endtask

    task automatic test_latency;
        reg_write(2'd1, 16'h0004);
        src = 7'h04;                 // rise at edge k
        tick(1);                     // k+1
        src = 7'h00;
        tick(1);                     // k+2
        sel(2'd0);
        n_checks++; if (dout[6:0] !== 7'h00) begin n_fail++; $display("FAIL lat_pend_k2: got %h expected 00", dout[6:0]); end
        tick(1);                     // k+3
        n_checks++; if (dout[6:0] !== 7'h04) begin n_fail++; $display("FAIL lat_pend_k3: got %h expected 04", dout[6:0]); end
        n_checks++; if (ipl_n !== 3'b111) begin n_fail++; $display("FAIL lat_ipl_k3: got %b expected 111", ipl_n); end
        tick(1);                     // k+4
        n_checks++; if (ipl_n !== 3'b100) begin n_fail++; $display("FAIL lat_ipl_k4: got %b expected 100", ipl_n); end
        n_checks++; if (irq_active !== 1'b1) begin n_fail++; $display("FAIL lat_active: got %b expected 1", irq_active); end
        reg_write(2'd0, 16'h0004);
        tick(1);
        n_checks++; if (ipl_n !== 3'b111) begin n_fail++; $display("FAIL lat_w1c_ipl: got %b expected 111", ipl_n); end
    endtask

    task automatic test_ack;
        reg_write(2'd1, 16'h007F);
        reg_write(2'd3, 16'h0012);   // levels 2 and 5
        tick(1);
        n_checks++; if (ipl_n !== 3'b010) begin n_fail++; $display("FAIL ack_ipl_pre: got %b expected 010", ipl_n); end
        iack = 1'b1; iack_level = 3'd5;
        tick(1);
        sel(2'd0);
        n_checks++; if (dout[6:0] !== 7'h02) begin n_fail++; $display("FAIL ack_pend: got %h expected 02", dout[6:0]); end
        n_checks++; if (dout[11] !== 1'b1) begin n_fail++; $display("FAIL ack_status: got %b expected 1", dout[11]); end
        n_checks++; if (ipl_n !== 3'b111) begin n_fail++; $display("FAIL ack_ipl_held: got %b expected 111", ipl_n); end
        tick(2);
        n_checks++; if (ipl_n !== 3'b111) begin n_fail++; $display("FAIL ack_ipl_held2: got %b expected 111", ipl_n); end
        iack = 1'b0;
        tick(1);
        n_checks++; if (ipl_n !== 3'b111) begin n_fail++; $display("FAIL ack_ipl_release: got %b expected 111", ipl_n); end
        tick(1);
        n_checks++; if (ipl_n !== 3'b101) begin n_fail++; $display("FAIL ack_ipl_after: got %b expected 101", ipl_n); end
        reg_write(2'd0, 16'h0002);
        tick(1);
    endtask

    task automatic test_level;
        reg_write(2'd2, 16'h007E);
        reg_write(2'd1, 16'h0001);
        src = 7'h01;
        tick(4);
        n_checks++; if (ipl_n !== 3'b110) begin n_fail++; $display("FAIL lvl_ipl: got %b expected 110", ipl_n); end
        reg_write(2'd0, 16'h0001);
        sel(2'd0);
        n_checks++; if (dout[0] !== 1'b1) begin n_fail++; $display("FAIL lvl_w1c_blocked: got %b expected 1", dout[0]); end
        src = 7'h00;
        tick(3);
        n_checks++; if (dout[0] !== 1'b1) begin n_fail++; $display("FAIL lvl_sticky: got %b expected 1", dout[0]); end
        reg_write(2'd0, 16'h0001);
        sel(2'd0);
        n_checks++; if (dout[0] !== 1'b0) begin n_fail++; $display("FAIL lvl_w1c_clear: got %b expected 0", dout[0]); end
        tick(1);
        n_checks++; if (ipl_n !== 3'b111) begin n_fail++; $display("FAIL lvl_ipl_idle: got %b expected 111", ipl_n); end
        reg_write(2'd2, 16'h007F);
        reg_write(2'd1, 16'h0000);
    endtask

    task automatic test_collision;
        src = 7'h08;                 // rise at edge k
        tick(2);                     // k+2
        reg_write(2'd0, 16'h0008);   // W1C lands on k+3 with the detected edge
        sel(2'd0);
        n_checks++; if (dout[3] !== 1'b1) begin n_fail++; $display("FAIL col_set_wins: got %b expected 1", dout[3]); end
        reg_write(2'd0, 16'h0008);
        sel(2'd0);
        n_checks++; if (dout[3] !== 1'b0) begin n_fail++; $display("FAIL col_w1c_later: got %b expected 0", dout[3]); end
        src = 7'h00;
        reg_write(2'd1, 16'h0040);
        reg_write(2'd3, 16'h0040);
        sel(2'd3);
        n_checks++; if (dout !== 16'h0000) begin n_fail++; $display("FAIL force_read: got %h expected 0000", dout); end
        tick(1);
        n_checks++; if (ipl_n !== 3'b000) begin n_fail++; $display("FAIL force_ipl: got %b expected 000", ipl_n); end
        reg_write(2'd0, 16'hFF40);   // upper byte must be ignored
        reg_write(2'd1, 16'h0000);
        tick(1);
        sel(2'd0);
        n_checks++; if (dout !== 16'h0000) begin n_fail++; $display("FAIL col_cleanup: got %h expected 0000", dout); end
    endtask

    task automatic test_spurious;
        reg_write(2'd1, 16'h007F);
        reg_write(2'd3, 16'h0020);
        tick(1);
        n_checks++; if (ipl_n !== 3'b001) begin n_fail++; $display("FAIL spur_ipl_pre: got %b expected 001", ipl_n); end
        iack = 1'b1; iack_level = 3'd3;
        tick(1);
        sel(2'd0);
        n_checks++; if (dout[6:0] !== 7'h20) begin n_fail++; $display("FAIL spur_pend: got %h expected 20", dout[6:0]); end
        n_checks++; if (dout[11] !== 1'b1) begin n_fail++; $display("FAIL spur_status: got %b expected 1", dout[11]); end
        iack = 1'b0;
        tick(2);
        n_checks++; if (ipl_n !== 3'b001) begin n_fail++; $display("FAIL spur_ipl_post: got %b expected 001", ipl_n); end
        n_checks++; if (dout[10:8] !== 3'd6) begin n_fail++; $display("FAIL spur_cur_level: got %0d expected 6", dout[10:8]); end
    endtask

    task automatic test_reset_mid_ack;
        iack = 1'b1; iack_level = 3'd6;
        tick(1);
        reset = 1'b1;
        tick(1);
        n_checks++; if (ipl_n !== 3'b111) begin n_fail++; $display("FAIL rst_ack_ipl: got %b expected 111", ipl_n); end
        reset = 1'b0;
        sel(2'd1);
        n_checks++; if (dout !== 16'h0000) begin n_fail++; $display("FAIL rst_ack_mask: got %h expected 0000", dout); end
        sel(2'd0);
        n_checks++; if (dout !== 16'h0000) begin n_fail++; $display("FAIL rst_ack_status: got %h expected 0000", dout); end
        reg_write(2'd1, 16'h007F);
        reg_write(2'd3, 16'h0020);
        tick(3);
        sel(2'd0);
        n_checks++; if (dout[6:0] !== 7'h20) begin n_fail++; $display("FAIL rst_ack_noclr: got %h expected 20", dout[6:0]); end
        n_checks++; if (ipl_n !== 3'b001) begin n_fail++; $display("FAIL rst_ack_ipl2: got %b expected 001", ipl_n); end
        iack = 1'b0;
        tick(1);
        iack = 1'b1;
        tick(1);
        n_checks++; if (dout[6:0] !== 7'h00) begin n_fail++; $display("FAIL rst_ack_reack: got %h expected 00", dout[6:0]); end
        n_checks++; if (ipl_n !== 3'b111) begin n_fail++; $display("FAIL rst_ack_ipl3: got %b expected 111", ipl_n); end
        iack = 1'b0;
        tick(2);
    endtask

    initial begin
        reset = 1'b1; src = 7'h00; cs = 1'b0; wr = 2'b00; address = 2'd0;
        din = 16'h0000; iack = 1'b0; iack_level = 3'd0;
        test_reset;
        test_latency;
        test_ack;
        test_level;
        test_collision;
        test_spurious;
        test_reset_mid_ack;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/irq_controller.md
IRQ_CONTROLLER -- requirements
Module: irq_controller

Interface
REQ-001 SHALL provide parameter SYNC_STAGES, default 2, which sets the number of synchronizer flops on each src bit (minimum 1).
REQ-002 SHALL have port clk  in  1  system clock; all logic rises on posedge clk.
REQ-003 SHALL have port reset  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port src  in  7  raw interrupt sources; src[n] requests 68000 level n+1.
REQ-005 SHALL have port cs  in  1  register block select, decoded by the system bus.
REQ-006 SHALL have port wr  in  2  byte write strobes {upper, lower}, already qualified by cs and write.
REQ-007 SHALL have port address  in  2  register word offset (cpu A2:A1).
REQ-008 SHALL have port din  in  16  CPU write data.
REQ-009 SHALL have port dout  out  16  CPU read data, combinational from address.
REQ-010 SHALL have port iack  in  1  interrupt-acknowledge cycle in progress (FC==3'b111 and AS active).
REQ-011 SHALL have port iack_level  in  3  level being acknowledged (cpu A3:A1 during IACK).
REQ-012 SHALL have port ipl_n  out  3  active-low encoded level to the CPU IPL2n:IPL0n.
REQ-013 SHALL have port irq_active  out  1  high when the presented level (cur_level) is non-zero.

Function
REQ-014 SHALL pass each src bit through SYNC_STAGES flops; the edge detector SHALL compare the last stage with one further history flop.
REQ-015 SHALL hold pending[6:0]; when MODE[n]=1 (edge mode), pending[n] SHALL set on a synchronized rising edge of src[n].
REQ-016 When MODE[n]=0 (level mode), pending[n] SHALL be forced to 1 every cycle the synchronized src[n] is high, and SHALL be clearable only while it is low.
REQ-017 SHALL compute cur_level as a register holding the index+1 of the highest set bit of (pending & MASK), or 0 if none.
REQ-018 Latency: a src rise at clock edge k SHALL give pending at edge k+SYNC_STAGES+1 and ipl_n at edge k+SYNC_STAGES+2.
REQ-019 SHALL drive ipl_n = ~cur_level and irq_active = |cur_level.
REQ-020 SHALL implement ack FSM IDLE -> ACKED -> IDLE; in IDLE, cur_level SHALL update every cycle.
REQ-021 Rising edge of iack in IDLE SHALL move the FSM to ACKED; if iack_level==cur_level!=0 and MODE=1 for that level, the matching pending bit SHALL clear in the same cycle.
REQ-022 On a mismatched or zero iack_level (spurious ack), the FSM SHALL still enter ACKED and SHALL clear nothing.
REQ-023 In ACKED, cur_level SHALL be held at 0; on iack low the FSM SHALL return to IDLE, and priority SHALL be re-evaluated on the following edge.
REQ-024 Register offset 0 (PENDING): read {4'b0, state==ACKED, cur_level, 1'b0, pending}; a wr[0] write of 1 SHALL clear the corresponding pending bit (write-1-to-clear).
REQ-025 Register offset 1 (MASK): 7-bit read/write, bit n enables level n+1.
REQ-026 Register offset 2 (MODE): 7-bit read/write, 1 = edge, 0 = level.
REQ-027 Register offset 3 (FORCE): a wr[0] write of 1 SHALL set the corresponding pending bit; reads SHALL return 0.
REQ-028 Only wr[0] SHALL affect registers; wr[1] SHALL be ignored; unused read bits SHALL be 0.
REQ-029 Simultaneous events: set (edge, level, or FORCE) SHALL win over W1C or ack clear on the same bit in the same cycle.
REQ-030 A MASK write SHALL take effect on cur_level on the next edge while in IDLE; in ACKED it SHALL take effect only after the return to IDLE.
REQ-031 A MODE change from edge to level SHALL keep existing pending bits.

Reset
REQ-032 On reset: synchronizers, history flops and pending SHALL be 0, MASK=0x00, MODE=0x7F, cur_level=0, FSM=IDLE, ipl_n=3'b111, irq_active=0.
REQ-033 Reset asserted mid-acknowledge SHALL force IDLE; iack still high after reset SHALL NOT be treated as a new rising edge until it has been seen low.

Verification
REQ-034 MASK=0x04, MODE=0x7F, pulse src[2] for 1 cycle -> pending=0x04 at k+3 and ipl_n=3'b100 at k+4 (SYNC_STAGES=2).
REQ-035 With levels 2 and 5 pending and MASK=0x7F -> ipl_n=3'b010; iack with iack_level=5 -> pending=0x02 and ipl_n=3'b111 while iack is high; after iack drops, ipl_n=3'b101 one edge later.
REQ-036 MODE[0]=0, src[0] held high, W1C 0x01 -> pending[0] stays 1; after src[0] goes low, W1C clears it and ipl_n returns to 3'b111.
REQ-037 Rising edge of src[3] coincides with a W1C of 0x08 on the same edge -> pending[3]=1; FORCE=0x40 with MASK=0x40 -> ipl_n=3'b000.
REQ-038 iack with iack_level=3 while cur_level=6 -> no pending change, ACKED status bit reads 1, cur_level=6 after release.
REQ-039 Reset pulsed during ACKED with iack held high -> ipl_n=3'b111 and registers at reset values; no clear occurs until iack falls and rises again.
